// File: rtl/sprite_dma_if.sv
// Sprite DMA bus interface: memory read port plus register write port.
// The DMA is the master on both; video RAM and the sprite engine form the slave side.
interface sprite_dma_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_din;
   logic        reg_wr;
   logic [7:0]  reg_addr;
   logic [15:0] reg_data;

   modport master (
      output mem_addr,
      output mem_rd,
      input  mem_din,
      output reg_wr,
      output reg_addr,
      output reg_data
   );

   modport slave (
      input  mem_addr,
      input  mem_rd,
      output mem_din,
      input  reg_wr,
      input  reg_addr,
      input  reg_data
   );
endinterface

// File: rtl/sprite_dma.sv
// Sprite DMA: once per frame (falling edge of v_valid) or on a software kick,
// copies NUM_WORDS little-endian 16-bit words from video RAM into the sprite
// engine's register file. Each byte read takes two cycles of memory latency,
// so one word costs four cycles.
module sprite_dma #(
   parameter int         NUM_WORDS = 96,
   parameter logic [7:0] REG_BASE  = 8'h40
) (
   input  logic        clk_pixel,
   input  logic        rst_n,
   input  logic        v_valid,
   input  logic        start,
   input  logic        dma_enable,
   input  logic [15:0] dma_base,
   output logic        busy,
   output logic        done,
   sprite_dma_if.master bus
);

   // Word index needs to count up to 95, and {idx,1'b0} then fits 8 bits.
   localparam int IDX_W = 7;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LO,
      READ_LO,
      WAIT_HI,
      READ_HI
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        lo_q, lo_d;
   logic [15:0]       memAddr_q, memAddr_d;
   logic              memRd_q, memRd_d;
   logic              regWr_q, regWr_d;
   logic [7:0]        regAddr_q, regAddr_d;
   logic [15:0]       regData_q, regData_d;
   logic              done_q, done_d;
   logic              vValidOld_q;
   logic              trig;

   // Kick request: software start, or end of visible area when enabled.
   assign trig = start | (dma_enable & vValidOld_q & ~v_valid);

   // Next-state and output computation for the transfer sequencer.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      memAddr_d = memAddr_q;
      memRd_d   = memRd_q;
      regAddr_d = regAddr_q;
      regData_d = regData_q;
      regWr_d   = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (trig) begin
               ptr_d     = dma_base;
               memAddr_d = dma_base;
               memRd_d   = 1'b1;
               idx_d     = '0;
               state_d   = WAIT_LO;
            end
         end
         WAIT_LO: begin
            state_d = READ_LO;
         end
         READ_LO: begin
            lo_d      = bus.mem_din;
            memAddr_d = ptr_q + 16'd1;
            ptr_d     = ptr_q + 16'd1;
            state_d   = WAIT_HI;
         end
         WAIT_HI: begin
            state_d = READ_HI;
         end
         READ_HI: begin
            regData_d = {bus.mem_din, lo_q};
            regAddr_d = REG_BASE + {idx_q, 1'b0};
            regWr_d   = 1'b1;
            if (idx_q == LAST_IDX) begin
               memRd_d = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               memAddr_d = ptr_q + 16'd1;
               ptr_d     = ptr_q + 16'd1;
               idx_d     = idx_q + 7'd1;
               state_d   = WAIT_LO;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         idx_q       <= '0;
         lo_q        <= '0;
         memAddr_q   <= '0;
         memRd_q     <= 1'b0;
         regWr_q     <= 1'b0;
         regAddr_q   <= '0;
         regData_q   <= '0;
         done_q      <= 1'b0;
         vValidOld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         lo_q        <= lo_d;
         memAddr_q   <= memAddr_d;
         memRd_q     <= memRd_d;
         regWr_q     <= regWr_d;
         regAddr_q   <= regAddr_d;
         regData_q   <= regData_d;
         done_q      <= done_d;
         vValidOld_q <= v_valid;
      end
   end

   assign bus.mem_addr = memAddr_q;
   assign bus.mem_rd   = memRd_q;
   assign bus.reg_wr   = regWr_q;
   assign bus.reg_addr = regAddr_q;
   assign bus.reg_data = regData_q;
   assign done         = done_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: a default 96-word instance and a 2-word
// instance used for the address wrap case, both fed from one memory array.
module tb_sprite_dma;

   logic        clk_pixel;
   logic        rst_n;
   logic        v_valid;
   logic        start;
   logic        dma_enable;
   logic [15:0] dma_base;
   logic        busy0;
   logic        done0;

   logic        start1;
   logic        dmaEnable1;
   logic [15:0] dmaBase1;
   logic        busy1;
   logic        done1;

   logic [7:0]  mem [0:65535];

   int checks;
   int errors;

   // Statistics gathered by collect for the default instance.
   int          wrCount;
   int          doneCount;
   int          busyCycles;
   int          doneCyc;
   int          memRdSeen;
   logic        firstMemRd;
   logic [15:0] firstMemAddr;
   logic [7:0]  capAddr [0:127];
   logic [15:0] capData [0:127];
   int          capCyc  [0:127];

   sprite_dma_if bus0 ();
   sprite_dma_if bus1 ();

   assign bus0.mem_din = mem[bus0.mem_addr];
   assign bus1.mem_din = mem[bus1.mem_addr];

   sprite_dma dut0 (
      .clk_pixel  (clk_pixel),
      .rst_n      (rst_n),
      .v_valid    (v_valid),
      .start      (start),
      .dma_enable (dma_enable),
      .dma_base   (dma_base),
      .busy       (busy0),
      .done       (done0),
      .bus        (bus0.master)
   );

   sprite_dma #(.NUM_WORDS(2), .REG_BASE(8'h40)) dut1 (
      .clk_pixel  (clk_pixel),
      .rst_n      (rst_n),
      .v_valid    (v_valid),
      .start      (start1),
      .dma_enable (dmaEnable1),
      .dma_base   (dmaBase1),
      .busy       (busy1),
      .done       (done1),
      .bus        (bus1.master)
   );

   // Free-running pixel clock.
   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   // Observes dut0 for a number of cycles, sampling on falling edges.
   // With holdStart, start is kept high for as long as the DUT is busy.
   task automatic collect(input int cycles, input bit holdStart);
      wrCount    = 0;
      doneCount  = 0;
      busyCycles = 0;
      doneCyc    = -1;
      memRdSeen  = 0;
      for (int c = 1; c <= cycles; c++) begin
         @(negedge clk_pixel);
         if (c == 1) begin
            firstMemRd   = bus0.mem_rd;
            firstMemAddr = bus0.mem_addr;
         end
         if (bus0.mem_rd === 1'b1) memRdSeen++;
         if (busy0 === 1'b1) busyCycles++;
         if (done0 === 1'b1) begin
            doneCount++;
            doneCyc = c;
         end
         if (bus0.reg_wr === 1'b1) begin
            if (wrCount < 128) begin
               capAddr[wrCount] = bus0.reg_addr;
               capData[wrCount] = bus0.reg_data;
               capCyc[wrCount]  = c;
            end
            wrCount++;
         end
         start = (holdStart && busy0 === 1'b1) ? 1'b1 : 1'b0;
      end
   endtask

   // Checks a completed 96-word transfer of the 0x1000 table.
   task automatic test_full_result(input string tag);
      int badWords;
      int badGaps;
      logic [15:0] expData;
      logic [7:0]  expAddr;
      checks++;
      if (firstMemRd !== 1'b1 || firstMemAddr !== 16'h1000) begin
         errors++;
         $display("[TB] FAIL %s first_read: got rd=%b addr=%h expected rd=1 addr=1000", tag, firstMemRd, firstMemAddr);
      end
      checks++;
      if (wrCount !== 96) begin
         errors++;
         $display("[TB] FAIL %s wr_count: got %0d expected 96", tag, wrCount);
      end
      checks++;
      if (capAddr[0] !== 8'h40 || capData[0] !== 16'h0100) begin
         errors++;
         $display("[TB] FAIL %s word0: got addr=%h data=%h expected addr=40 data=0100", tag, capAddr[0], capData[0]);
      end
      checks++;
      if (capAddr[95] !== 8'hFE || capData[95] !== 16'hBFBE) begin
         errors++;
         $display("[TB] FAIL %s word95: got addr=%h data=%h expected addr=fe data=bfbe", tag, capAddr[95], capData[95]);
      end
      badWords = 0;
      badGaps  = 0;
      for (int k = 0; k < 96; k++) begin
         expAddr = 8'(8'h40 + 2 * k);
         expData = {8'(2 * k + 1), 8'(2 * k)};
         if (capAddr[k] !== expAddr || capData[k] !== expData) badWords++;
         if (k > 0 && capCyc[k] - capCyc[k-1] != 4) badGaps++;
      end
      checks++;
      if (badWords !== 0) begin
         errors++;
         $display("[TB] FAIL %s all_words: got %0d bad words expected 0", tag, badWords);
      end
      checks++;
      if (badGaps !== 0) begin
         errors++;
         $display("[TB] FAIL %s spacing: got %0d bad gaps expected 0", tag, badGaps);
      end
      checks++;
      if (doneCount !== 1 || doneCyc !== capCyc[95]) begin
         errors++;
         $display("[TB] FAIL %s done: got count=%0d cyc=%0d expected count=1 cyc=%0d", tag, doneCount, doneCyc, capCyc[95]);
      end
      checks++;
      if (busyCycles !== 384) begin
         errors++;
         $display("[TB] FAIL %s busy_cycles: got %0d expected 384", tag, busyCycles);
      end
   endtask

   // Reset values of every output.
   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus0.mem_addr, bus0.mem_rd, bus0.reg_wr, bus0.reg_addr, bus0.reg_data, busy0, done0} !== 44'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got addr=%h rd=%b wr=%b raddr=%h rdata=%h busy=%b done=%b expected all 0",
                  bus0.mem_addr, bus0.mem_rd, bus0.reg_wr, bus0.reg_addr, bus0.reg_data, busy0, done0);
      end
      repeat (3) @(negedge clk_pixel);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_pixel);
   endtask

   // Frame-end trigger via falling v_valid.
   task automatic test_vvalid_transfer();
      dma_enable = 1'b1;
      dma_base   = 16'h1000;
      v_valid    = 1'b0;
      collect(420, 1'b0);
      test_full_result("vvalid");
      v_valid = 1'b1;
      @(negedge clk_pixel);
   endtask

   // dma_enable gates v_valid but not start.
   task automatic test_enable_gate();
      dma_enable = 1'b0;
      v_valid    = 1'b0;
      collect(20, 1'b0);
      checks++;
      if (memRdSeen !== 0 || wrCount !== 0) begin
         errors++;
         $display("[TB] FAIL gated_edge: got rd_cycles=%0d wr=%0d expected 0 0", memRdSeen, wrCount);
      end
      start = 1'b1;
      collect(420, 1'b0);
      test_full_result("start");
      dma_enable = 1'b1;
      v_valid    = 1'b1;
      @(negedge clk_pixel);
   endtask

   // start held during a transfer is ignored; a later start works.
   task automatic test_start_flood();
      start = 1'b1;
      collect(420, 1'b1);
      checks++;
      if (wrCount !== 96 || doneCount !== 1) begin
         errors++;
         $display("[TB] FAIL flood: got wr=%0d done=%0d expected 96 1", wrCount, doneCount);
      end
      start = 1'b1;
      collect(420, 1'b0);
      test_full_result("restart");
   endtask

   // Start and v_valid edge together give a single transfer.
   task automatic test_simultaneous();
      v_valid = 1'b0;
      start   = 1'b1;
      collect(420, 1'b0);
      checks++;
      if (wrCount !== 96 || doneCount !== 1) begin
         errors++;
         $display("[TB] FAIL simultaneous: got wr=%0d done=%0d expected 96 1", wrCount, doneCount);
      end
      collect(20, 1'b0);
      checks++;
      if (memRdSeen !== 0) begin
         errors++;
         $display("[TB] FAIL simultaneous_extra: got rd_cycles=%0d expected 0", memRdSeen);
      end
      v_valid = 1'b1;
      @(negedge clk_pixel);
   endtask

   // Address wrap through 0xFFFF on the two-word instance.
   task automatic test_wrap();
      dmaBase1 = 16'hFFFF;
      start1   = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_pixel);
         start1 = 1'b0;
         if (c == 1 || c == 3 || c == 5 || c == 7) begin
            logic [15:0] expAddr;
            expAddr = (c == 1) ? 16'hFFFF : (c == 3) ? 16'h0000 : (c == 5) ? 16'h0001 : 16'h0002;
            checks++;
            if (bus1.mem_addr !== expAddr || bus1.mem_rd !== 1'b1) begin
               errors++;
               $display("[TB] FAIL wrap_addr_c%0d: got addr=%h rd=%b expected addr=%h rd=1", c, bus1.mem_addr, bus1.mem_rd, expAddr);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus1.reg_wr !== 1'b1 || bus1.reg_addr !== 8'h40 || bus1.reg_data !== 16'h2211 || done1 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL wrap_word0: got wr=%b addr=%h data=%h done=%b expected 1 40 2211 0",
                        bus1.reg_wr, bus1.reg_addr, bus1.reg_data, done1);
            end
         end
         if (c == 9) begin
            checks++;
            if (bus1.reg_wr !== 1'b1 || bus1.reg_addr !== 8'h42 || bus1.reg_data !== 16'h4433 ||
                done1 !== 1'b1 || busy1 !== 1'b0 || bus1.mem_rd !== 1'b0) begin
               errors++;
               $display("[TB] FAIL wrap_word1: got wr=%b addr=%h data=%h done=%b busy=%b rd=%b expected 1 42 4433 1 0 0",
                        bus1.reg_wr, bus1.reg_addr, bus1.reg_data, done1, busy1, bus1.mem_rd);
            end
         end
         if (c == 10) begin
            checks++;
            if (bus1.reg_wr !== 1'b0 || done1 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL wrap_after: got wr=%b done=%b expected 0 0", bus1.reg_wr, done1);
            end
         end
      end
   endtask

   // Reset in the middle of a transfer aborts it without a done pulse.
   task automatic test_reset_mid();
      start = 1'b1;
      collect(50, 1'b0);
      checks++;
      if (wrCount !== 12 || doneCount !== 0) begin
         errors++;
         $display("[TB] FAIL mid_progress: got wr=%0d done=%0d expected 12 0", wrCount, doneCount);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus0.mem_addr, bus0.mem_rd, bus0.reg_wr, bus0.reg_addr, bus0.reg_data, busy0, done0} !== 44'h0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got addr=%h rd=%b wr=%b raddr=%h rdata=%h busy=%b done=%b expected all 0",
                  bus0.mem_addr, bus0.mem_rd, bus0.reg_wr, bus0.reg_addr, bus0.reg_data, busy0, done0);
      end
      v_valid = 1'b0;
      repeat (2) @(negedge clk_pixel);
      rst_n = 1'b1;
      collect(20, 1'b0);
      checks++;
      if (memRdSeen !== 0 || wrCount !== 0 || doneCount !== 0 || busyCycles !== 0) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got rd=%0d wr=%0d done=%0d busy=%0d expected 0 0 0 0",
                  memRdSeen, wrCount, doneCount, busyCycles);
      end
      v_valid = 1'b1;
   endtask

   // Test sequence.
   initial begin
      checks     = 0;
      errors     = 0;
      v_valid    = 1'b1;
      start      = 1'b0;
      dma_enable = 1'b1;
      dma_base   = 16'h1000;
      start1     = 1'b0;
      dmaEnable1 = 1'b0;
      dmaBase1   = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 192; i++) mem[16'h1000 + i] = 8'(i);
      mem[16'hFFFF] = 8'h11;
      mem[16'h0000] = 8'h22;
      mem[16'h0001] = 8'h33;
      mem[16'h0002] = 8'h44;

      test_reset();
      test_vvalid_transfer();
      test_enable_gate();
      test_start_flood();
      test_simultaneous();
      test_wrap();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_dma.md
Name: sprite_dma

Overview:
- Register-bus initiator that refreshes the sprite position/look register file from a table in video memory once per frame.
- Reads little-endian 16-bit words from memory over the shared 8-bit read port, then writes each word to the sprite block's register bus.
- Sits between video RAM and the sprite engine; its reg_wr/reg_addr/reg_data outputs drive the sprite engine's register inputs.

Parameters:
- NUM_WORDS, 96, number of words per transfer; legal range 1..96.
- REG_BASE, 8'h40, register address of word 0. Word i goes to REG_BASE+2*i. Constraint: REG_BASE+2*(NUM_WORDS-1) <= 8'hFE.

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- v_valid  input  1  vertical-visible flag; its falling edge triggers a transfer.
- start  input  1  one-cycle software kick; triggers a transfer.
- dma_enable  input  1  gates the v_valid trigger only.
- dma_base  input  16  byte address of the table; latched at transfer start.
- mem_addr  output  16  memory byte address.
- mem_rd  output  1  memory read request.
- mem_din  input  8  memory read data.
- reg_wr  output  1  register write strobe, one cycle per word.
- reg_addr  output  8  register address.
- reg_data  output  16  register data.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at transfer completion.

Behaviour:
- Reset values: mem_addr=0, mem_rd=0, reg_wr=0, reg_addr=0, reg_data=0, busy=0, done=0, state=IDLE, word index=0, v_valid edge register=0. The edge register resets to 0, so reset never produces a false edge.
- Trigger: trig = start | (dma_enable & old_v_valid & ~v_valid). It is sampled only in IDLE and ignored while busy; no queueing.
- A simultaneous start and v_valid edge produce exactly one transfer.
- Memory timing: mem_din is sampled on the 2nd rising edge after the edge that registers mem_addr. mem_rd is held high for the whole transfer.
- States: IDLE, WAIT_LO, READ_LO, WAIT_HI, READ_HI.
- IDLE, when trig:
  - ptr<=dma_base, mem_addr<=dma_base, mem_rd<=1, idx<=0.
  - Go to WAIT_LO.
- WAIT_LO -> READ_LO.
- READ_LO:
  - lo<=mem_din.
  - mem_addr<=ptr+1, ptr<=ptr+1.
  - Go to WAIT_HI.
- WAIT_HI -> READ_HI.
- READ_HI:
  - reg_data<={mem_din,lo}, reg_addr<=REG_BASE+{idx,1'b0}, reg_wr<=1.
  - If idx==NUM_WORDS-1: mem_rd<=0, done<=1, go to IDLE.
  - Else: mem_addr<=ptr+1, ptr<=ptr+1, idx<=idx+1, go to WAIT_LO.
- reg_wr and done are forced to 0 on every edge that does not set them, so each is exactly one cycle wide.
- busy is a combinational function of state (state!=IDLE). On the final word, busy falls in the same cycle that reg_wr and done are high.
- Throughput: 4 cycles per word. Whole transfer = 4*NUM_WORDS cycles; 384 for the default.
- Address arithmetic is modulo 2^16, so a table starting at 16'hFFFF wraps to 16'h0000.
- reg_addr arithmetic is 8-bit and never exceeds 8'hFE when the parameter constraint holds.
- dma_base and dma_enable changes mid-transfer have no effect on the transfer in progress.
- rst_n asserted mid-transfer:
  - Immediate return to reset values.
  - No further reg_wr; partially written registers keep their values.
  - No done pulse.

Test Plan:
- Table at 16'h1000 holding bytes 00,01,02,03,...; dma_enable=1; v_valid 1->0 -> mem_rd rises next edge. First reg_wr carries reg_addr=8'h40, reg_data=16'h0100. Word 95 gives reg_addr=8'hFE, reg_data=16'hBFBE. Exactly 96 reg_wr pulses spaced 4 cycles apart; done coincides with the last pulse; busy high for 384 cycles.
- dma_enable=0 with a v_valid falling edge -> no mem_rd, no reg_wr. Then a start pulse -> full transfer identical to the first scenario.
- start pulsed every cycle during a transfer -> still exactly 96 reg_wr and one done. The next start after done begins a new transfer.
- dma_base=16'hFFFF, NUM_WORDS=2 -> mem_addr sequence FFFF,0000,0001,0002. Data bytes 11,22,33,44 -> reg_data 2211 then 4433.
- rst_n low at cycle 50 of a transfer -> all outputs 0 asynchronously. No done pulse, no reg_wr after reset. Releasing reset with v_valid held low -> no spurious transfer.
- start and a v_valid falling edge in the same cycle -> single transfer, 96 reg_wr.
